fdiv_scheduler: RTL and testbench
=================================

Name: fdiv_scheduler

Overview:
- Shares one single-operation (non-pipelined) floating-point divider among NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready request handshake per requester.
- Sequences the divider's enable and operands, waits a fixed latency, then returns the IEEE-754 single-precision quotient with the requester ID and a divide-by-zero flag.
- Sits between the FP ALU front end and the FloatingDivision instance; the divider is driven through the div_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).
- DIV_LATENCY, 2, cycles the divider needs from operand sampling to a valid result (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  32*NUM_REQ  dividend per requester; requester i occupies bits [32i+31:32i]
- req_b  in  32*NUM_REQ  divisor per requester; same packing as req_a
- req_ready  out  NUM_REQ  one-hot acceptance strobe
- div_en  out  1  divider enable
- div_a  out  32  divider operand A
- div_b  out  32  divider operand B
- div_result  in  32  divider quotient
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_data  out  32  quotient
- rsp_dbz  out  1  divisor was +0 or -0
- busy  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE
  - all outputs = 0
  - rr_ptr = NUM_REQ-1, so requester 0 has highest priority first
  - in-flight operation discarded; no response issued for it
- IDLE:
  - If any req_valid is high, grant g = first requester with req_valid high, searching from rr_ptr+1 modulo NUM_REQ.
  - req_ready[g] is driven combinationally high in that same cycle; the request is accepted on that edge.
  - On acceptance, latch A, B and g; latch dbz = (B[30:0]==0). Go to ISSUE.
  - req_ready is 0 in every state other than IDLE.
- ISSUE (1 cycle):
  - div_en=1; div_a and div_b driven from the latched operands.
  - The divider samples its operands at the closing edge. Load cnt = DIV_LATENCY-1. Go to WAIT.
- WAIT:
  - div_en=1; operands held stable.
  - Decrement cnt each cycle. At the edge where cnt==0, capture div_result into rsp_data and go to RESP.
  - WAIT therefore lasts exactly DIV_LATENCY cycles.
- RESP:
  - div_en=0.
  - rsp_valid=1; rsp_id, rsp_data and rsp_dbz are held stable until the rsp_valid && rsp_ready edge.
  - On that edge: rr_ptr = granted ID, go to IDLE.
  - Deasserting rsp_ready stalls indefinitely; no new request is accepted while stalled.
- Latency:
  - rsp_valid rises DIV_LATENCY+1 cycles after the accepting edge.
  - Minimum issue-to-issue spacing is DIV_LATENCY+3 cycles.
- Data rules:
  - rsp_dbz is set for divisor 0x00000000 or 0x80000000 only.
  - rsp_data is always exactly the divider's output; the scheduler does no substitution.
- Request behaviour:
  - Requests are not queued. A requester keeps req_valid high until it sees req_ready.
  - Dropping req_valid before a grant is legal and has no side effects.
- Boundary conditions:
  - req_valid for a requester is ignored while it is not granted.
  - A simultaneous req_valid on every input yields exactly one grant per IDLE visit.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - rsp_ready high before rsp_valid is harmless.
  - A reset in RESP drops rsp_valid immediately, asynchronously.

Decomposition:
- Shared package fp_alu_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - FP_W = 32
  - constants FP_POS_ZERO = 32'h00000000 and FP_NEG_ZERO = 32'h80000000
- One natural sub-module: rr_arbiter (NUM_REQ, pointer-based round-robin, combinational grant plus a registered pointer update on a strobe).
- The FSM, latency counter and datapath registers stay in fdiv_scheduler.
- The FloatingDivision instance lives outside this block.

Test Plan:
- Single request: req0 A=0x411C0000 (9.75), B=0x40800000 (4.0); behavioural divider model with DIV_LATENCY=2.
  -> req_ready[0] pulses one cycle; div_en high for 3 cycles; rsp_valid 3 cycles after acceptance; rsp_id=0; rsp_data=0x401C0000 (2.4375); rsp_dbz=0.
- Sign handling: req2 A=0x41B26666 (22.3), B=0xBF000000 (-0.5).
  -> rsp_id=2; rsp_data=0xC2326666 (-44.6); rsp_dbz=0.
- Divide by zero: req1 A=0x3FA66666 (1.3), B=0x80000000.
  -> rsp_dbz=1; rsp_data equals the model output unchanged.
- Round robin: all four req_valid held high from reset, distinct operands, rsp_ready=1.
  -> grant order 0,1,2,3,0; each rsp_id matches its operands; no grant while busy.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid while req3 is pending.
  -> rsp_* stable for all 10 cycles; req_ready stays 0; req3 is granted the cycle after the response handshake.
- Reset mid-operation: assert rst during WAIT.
  -> outputs drop to 0 without waiting for a clock edge; state is IDLE; the next grant goes to requester 0; no stale rsp_valid.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared FP ALU types and constants: scheduler states and IEEE-754 single-precision zero encodings.
package fp_alu_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic fp_is_zero(input logic [FP_W-1:0] v);
        return (v == FP_POS_ZERO) || (v == FP_NEG_ZERO);
    endfunction

endpackage

// File: rtl/fdiv_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant searched from ptr+1,
// pointer reloaded with the served ID on upd_en.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd_en,
    input  logic [ID_W-1:0]    upd_id,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_d = upd_en ? upd_id : ptr_q;

    // Walk from the lowest priority back to the highest so the last hit wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (req[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
        if (grant_vld) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv_scheduler.sv
// Shares one fixed-latency FP divider among NUM_REQ requesters with round-robin
// arbitration; returns quotient, owner ID and divide-by-zero flag.
module fdiv_scheduler
    import fp_alu_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int DIV_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  div_en,
    output logic [31:0]           div_a,
    output logic [31:0]           div_b,
    input  logic [31:0]           div_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_dbz,
    output logic                  busy
);

    localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    state_e            state_q, state_d;
    logic [FP_W-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              dbz_q, dbz_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_vld;
    logic               rsp_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .upd_en    (rsp_hs),
        .upd_id    (id_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            id_q    <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            id_q    <= id_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        id_d      = id_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        div_en    = 1'b0;
        rsp_hs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = grant;
                if (grant_vld) begin
                    a_d     = req_a[32*grant_id +: 32];
                    b_d     = req_b[32*grant_id +: 32];
                    id_d    = grant_id;
                    dbz_d   = fp_is_zero(req_b[32*grant_id +: 32]);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                div_en  = 1'b1;
                cnt_d   = CNT_W'(DIV_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                div_en = 1'b1;
                if (cnt_q == '0) begin
                    data_d  = div_result;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign div_a     = a_q;
    assign div_b     = b_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_dbz   = dbz_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fdiv_scheduler.sv
// Directed + randomized bench for fdiv_scheduler with a behavioural divider and a
// transaction-level round-robin reference model.
module tb_fdiv_scheduler;

    localparam int N = 4;
    localparam int L = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            div_en;
    logic [31:0]     div_a;
    logic [31:0]     div_b;
    logic [31:0]     div_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_dbz;
    logic            busy;

    fdiv_scheduler #(
        .NUM_REQ     (N),
        .ID_W        (2),
        .DIV_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .div_en     (div_en),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_dbz    (rsp_dbz),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Known quotients for the directed cases; an arbitrary mixing function otherwise.
    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h411C_0000 && b == 32'h4080_0000) return 32'h401C_0000;
        if (a == 32'h41B2_6666 && b == 32'hBF00_0000) return 32'hC232_6666;
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return (a ^ {b[15:0], b[31:16]}) + 32'h1234_5678;
    endfunction

    // Divider: samples operands on the first enabled edge, result valid L cycles later.
    int          age = 0;
    logic [31:0] lat_a, lat_b;
    always @(posedge clk) begin
        if (!div_en) begin
            age <= 0;
        end else begin
            if (age == 0) begin
                lat_a <= div_a;
                lat_b <= div_b;
            end
            if (age < 1000) age <= age + 1;
        end
    end
    assign div_result = (div_en && age >= L) ? div_model(lat_a, lat_b) : 32'hDEAD_BEEF;

    int          total  = 0;
    int          passed = 0;
    bit          pv[N];
    logic [31:0] pa[N];
    logic [31:0] pb[N];
    int          last_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = pv[i];
            req_a[32*i +: 32] = pa[i];
            req_b[32*i +: 32] = pb[i];
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= N; k++) begin
            if (pv[(last_id + k) % N]) return (last_id + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int g);
        return (g < 0) ? 32'd0 : (32'd1 << g);
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        pv[i] = 1'b1;
        pa[i] = a;
        pb[i] = b;
    endtask

    // Called in an IDLE cycle; runs one full transaction and ends in the following IDLE cycle.
    task automatic serve(input int stall);
        int          g;
        logic [31:0] ea, eb, er, edbz;
        g = model_grant();
        drive();
        #1;
        chk("req_ready_grant", 32'(req_ready), onehot(g));
        chk("busy_idle", 32'(busy), 32'd0);
        if (g < 0) return;
        ea   = pa[g];
        eb   = pb[g];
        er   = div_model(ea, eb);
        edbz = (eb[30:0] == 31'd0) ? 32'd1 : 32'd0;
        if (stall > 0) rsp_ready = 1'b0;
        step();
        pv[g] = 1'b0;
        drive();
        for (int c = 0; c <= L; c++) begin
            #1;
            chk("div_en_active", 32'(div_en), 32'd1);
            chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("busy_active", 32'(busy), 32'd1);
            chk("div_a", div_a, ea);
            chk("div_b", div_b, eb);
            step();
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_data", rsp_data, er);
        chk("rsp_dbz", 32'(rsp_dbz), edbz);
        chk("div_en_resp", 32'(div_en), 32'd0);
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            step();
            #1;
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_id", 32'(rsp_id), 32'(g));
            chk("stall_rsp_data", rsp_data, er);
            chk("stall_rsp_dbz", 32'(rsp_dbz), edbz);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        last_id = g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        last_id = N - 1;
        drive();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
        end
        last_id = N - 1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_div_en", 32'(div_en), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", div_b, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_dbz", 32'(rsp_dbz), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // Single request, sign handling, divide by zero
        set_req(0, 32'h411C_0000, 32'h4080_0000);
        serve(0);
        set_req(2, 32'h41B2_6666, 32'hBF00_0000);
        serve(0);
        set_req(1, 32'h3FA6_6666, 32'h8000_0000);
        serve(0);

        // Round robin from reset with all requesters pending
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i << 4));
        serve(0);
        set_req(0, 32'h4120_0000, 32'h4040_0000);
        serve(0);
        serve(0);
        serve(0);
        serve(0);

        // Backpressure with requester 3 waiting
        set_req(1, 32'h4248_0000, 32'h4100_0000);
        set_req(3, 32'hC0A0_0000, 32'h0000_0000);
        serve(10);
        serve(0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 5))
                        0:       set_req(i, $urandom, 32'h0000_0000);
                        1:       set_req(i, $urandom, 32'h8000_0000);
                        2:       set_req(i, $urandom, 32'h0000_0001);
                        default: set_req(i, $urandom, $urandom);
                    endcase
                end else if (pv[i] && $urandom_range(0, 7) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            if (!(pv[0] || pv[1] || pv[2] || pv[3])) begin
                set_req(int'($urandom_range(0, N - 1)), $urandom, $urandom);
            end
            serve(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in WAIT
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        set_req(2, 32'h4000_0000, 32'h3F80_0000);
        drive();
        step();
        pv[2] = 1'b0;
        drive();
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_div_en", 32'(div_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_div_a", div_a, 32'd0);
        chk("async_rst_div_b", div_b, 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        #1;
        rst = 1'b0;
        last_id = N - 1;
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        step();
        set_req(2, 32'h4040_0000, 32'h4000_0000);
        set_req(0, 32'h40A0_0000, 32'h4080_0000);
        serve(0);
        serve(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
